// File: rtl/tdp_ram_1clk.sv
// Single-clock true dual-port RAM with synchronous reads and an optional output register.
// Port A wins a same-address write collision. Each port reads its own write data
// (write-through). A port reading an address the other port is writing sees the old word.
// Only the read-data registers are reset; the storage array keeps its contents.

module tdp_ram_1clk #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned REGISTER_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
    logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
    logic                  wr_b_en;

    // Port B's write is dropped when port A writes the same word in the same cycle.
    always_comb begin
        wr_b_en = we_b;
        if (we_a && we_b && (addr_a == addr_b)) begin
            wr_b_en = 1'b0;
        end
    end

    // Read-register next state: own write data on a write, otherwise the stored (old) word.
    always_comb begin
        rd_a_d = mem[addr_a];
        rd_b_d = mem[addr_b];
        if (we_a) begin
            rd_a_d = data_a;
        end
        if (we_b) begin
            rd_b_d = data_b;
        end
    end

    // Storage array: no reset, writes suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                mem[addr_a] <= data_a;
            end
            if (wr_b_en) begin
                mem[addr_b] <= data_b;
            end
        end
    end

    // First read stage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    if (REGISTER_OUT != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_a_q;
        logic [DATA_WIDTH-1:0] out_b_q;

        // Optional output stage adding one cycle of read latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_a_q <= '0;
                out_b_q <= '0;
            end else begin
                out_a_q <= rd_a_q;
                out_b_q <= rd_b_q;
            end
        end

        assign q_a = out_a_q;
        assign q_b = out_b_q;
    end else begin : g_no_out_reg
        assign q_a = rd_a_q;
        assign q_b = rd_b_q;
    end

endmodule

// File: tb/tb_tdp_ram_1clk.sv
// Self-checking bench: two instances (1- and 2-cycle latency) share one stimulus stream and
// are compared against a word-array reference model plus directed constant expectations.

module tb_tdp_ram_1clk;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          we_a = 1'b0;
    logic          we_b = 1'b0;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;

    always #5 clk = ~clk;

    tdp_ram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_OUT(0)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (addr_a),
        .data_a (data_a),
        .we_a   (we_a),
        .q_a    (q_a0),
        .addr_b (addr_b),
        .data_b (data_b),
        .we_b   (we_b),
        .q_b    (q_b0)
    );

    tdp_ram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGISTER_OUT(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (addr_a),
        .data_a (data_a),
        .we_a   (we_a),
        .q_a    (q_a1),
        .addr_b (addr_b),
        .data_b (data_b),
        .we_b   (we_b),
        .q_b    (q_b1)
    );

    // Reference model: word array with written-flags, and the last two read results per port.
    logic [DW-1:0] mem_m [DEPTH];
    bit            mem_v [DEPTH];
    logic [DW-1:0] p0_a, p1_a, p0_b, p1_b;
    bit            v0_a, v1_a, v0_b, v1_b;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        if (v0_a) chk({tag, "/q_a0"}, q_a0, p0_a);
        if (v0_b) chk({tag, "/q_b0"}, q_b0, p0_b);
        if (v1_a) chk({tag, "/q_a1"}, q_a1, p1_a);
        if (v1_b) chk({tag, "/q_b1"}, q_b1, p1_b);
    endtask

    task automatic model_clear();
        p0_a = '0; p1_a = '0; p0_b = '0; p1_b = '0;
        v0_a = 1'b1; v1_a = 1'b1; v0_b = 1'b1; v1_b = 1'b1;
    endtask

    // One clock: drive, apply the edge to the model, check 1 time unit after the edge.
    task automatic step(input string tag,
                        input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic [DW-1:0] ea, eb;
        bit            eva, evb;
        we_a = wa; addr_a = aa; data_a = da;
        we_b = wb; addr_b = ab; data_b = db;
        @(posedge clk);
        if (rst_n) begin
            ea  = wa ? da : mem_m[aa];
            eva = wa || mem_v[aa];
            eb  = wb ? db : mem_m[ab];
            evb = wb || mem_v[ab];
            p1_a = p0_a; v1_a = v0_a; p0_a = ea; v0_a = eva;
            p1_b = p0_b; v1_b = v0_b; p0_b = eb; v0_b = evb;
            if (wb) begin mem_m[ab] = db; mem_v[ab] = 1'b1; end
            if (wa) begin mem_m[aa] = da; mem_v[aa] = 1'b1; end
        end
        #1;
        check_all(tag);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_reset");
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_v[i] = 1'b0;
        #1;
        model_clear();
        check_all("reset_state");
        release_reset();

        // Fill via port A while port B trails one address behind.
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, AW'(i), DW'(i), 1'b0, AW'(i - 1), '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step("readback", 1'b0, '0, '0, 1'b0, AW'(i), '0);
            chk("readback_const", q_b0, DW'(i));
        end

        // Write-through on A, old data on B for the same address.
        step("wt_pre", 1'b1, AW'(7), 8'h11, 1'b0, '0, '0);
        step("wt", 1'b1, AW'(7), 8'h5A, 1'b0, AW'(7), '0);
        chk("wt_qa", q_a0, 8'h5A);
        chk("wt_qb_old", q_b0, 8'h11);
        step("wt_after", 1'b0, AW'(7), '0, 1'b0, AW'(7), '0);
        chk("wt_qb_new", q_b0, 8'h5A);

        // Collision: A wins; different addresses both succeed.
        step("coll", 1'b1, AW'(4), 8'h33, 1'b1, AW'(4), 8'hCC);
        chk("coll_qa", q_a0, 8'h33);
        chk("coll_qb", q_b0, 8'hCC);
        step("dual_wr", 1'b1, AW'(1), 8'hA1, 1'b1, AW'(2), 8'hB2);
        step("coll_rd", 1'b0, AW'(4), '0, 1'b0, AW'(1), '0);
        chk("coll_mem4", q_a0, 8'h33);
        chk("dual_mem1", q_b0, 8'hA1);
        step("dual_rd", 1'b0, AW'(2), '0, 1'b0, AW'(2), '0);
        chk("dual_mem2", q_a0, 8'hB2);

        // Async reset mid-cycle; contents survive and writes during reset are dropped.
        step("pre_wr3", 1'b1, AW'(3), 8'hA5, 1'b0, AW'(7), '0);
        step("pre_rd7", 1'b0, AW'(7), '0, 1'b0, AW'(7), '0);
        chk("pre_rst_qa", q_a0, 8'h5A);
        mid_reset();
        chk("rst_qa0", q_a0, 8'h00);
        chk("rst_qb0", q_b0, 8'h00);
        step("in_reset", 1'b1, AW'(7), 8'hFF, 1'b1, AW'(3), 8'hEE);
        release_reset();
        step("lat1", 1'b0, AW'(3), '0, 1'b0, AW'(7), '0);
        chk("lat1_qa0", q_a0, 8'hA5);
        chk("lat1_qb0", q_b0, 8'h5A);
        chk("lat1_qa1_zero", q_a1, 8'h00);
        step("lat2", 1'b0, AW'(3), '0, 1'b0, AW'(7), '0);
        chk("lat2_qa1", q_a1, 8'hA5);

        // Sort-style swap using the read results as write data.
        step("swap_init", 1'b1, AW'(0), 8'h10, 1'b1, AW'(1), 8'h20);
        step("swap_rd", 1'b0, AW'(1), '0, 1'b0, AW'(0), '0);
        chk("swap_rd_qa", q_a0, 8'h20);
        chk("swap_rd_qb", q_b0, 8'h10);
        step("swap_wr", 1'b1, AW'(1), q_b0, 1'b1, AW'(0), q_a0);
        step("swap_chk", 1'b0, AW'(0), '0, 1'b0, AW'(1), '0);
        chk("swap_mem0", q_a0, 8'h20);
        chk("swap_mem1", q_b0, 8'h10);

        // Random traffic, biased toward a few addresses to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            rb = ($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            step("rand", 1'($urandom_range(0, 1)), ra, DW'($urandom),
                 1'($urandom_range(0, 1)), rb, DW'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
                step("rand_in_reset", 1'b1, ra, DW'($urandom), 1'b1, rb, DW'($urandom));
                release_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
